uart_tx: RTL

Serial transmitter for the UART link. It is the stage directly upstream of the receiver on the serial wire. It accepts parallel bytes through a load/ready handshake, buffers one byte behind the byte currently being shifted, and drives an 8N1 (or 8N2) frame LSB-first at a fixed baud rate derived from the system clock. Its serial output connects to the receiver's serial input, either on the board or in loopback benches.

---
 rtl/uart_tx.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1/8N2 UART transmitter with one-byte holding register
module uart_tx #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 9600,
    parameter int STOP_BITS = 1
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] DataIn,
    input  logic       load,
    output logic       ready,
    output logic       busy,
    output logic       drop,
    output logic       TxD
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic          SC_MAX  = 1'(STOP_BITS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]    state;
    logic [7:0]    hold;
    logic          hold_v;
    logic [7:0]    shift;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic          stop_cnt;
    logic          baud_end;
    logic          stop_end;
    logic          xfer;

    assign baud_end = (cnt == CNT_MAX);
    assign stop_end = (state == S_STOP) && baud_end && (stop_cnt == SC_MAX);
    // A held byte moves into the shifter either from idle or straight off the last stop clock.
    assign xfer     = hold_v && ((state == S_IDLE) || stop_end);

    assign ready = !hold_v;
    assign busy  = (state != S_IDLE);

    // Holding register: accept on load while empty, release on transfer, flag overruns.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            hold   <= 8'h00;
            hold_v <= 1'b0;
            drop   <= 1'b0;
        end else begin
            drop <= load && hold_v;
            if (xfer) begin
                hold_v <= 1'b0;
            end else if (load && !hold_v) begin
                hold   <= DataIn;
                hold_v <= 1'b1;
            end
        end
    end

    // Shift register: loaded on transfer, shifted right at the end of each data bit.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            shift <= 8'h00;
        end else if (xfer) begin
            shift <= hold;
        end else if ((state == S_DATA) && baud_end) begin
            shift <= {1'b0, shift[7:1]};
        end
    end

    // Frame sequencer: baud counter, bit index and stop counter per state.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_idx  <= 3'd0;
            stop_cnt <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (hold_v) begin
                        state <= S_START;
                        cnt   <= '0;
                    end
                end
                S_START: begin
                    if (baud_end) begin
                        cnt     <= '0;
                        bit_idx <= 3'd0;
                        state   <= S_DATA;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (baud_end) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            stop_cnt <= 1'b0;
                            state    <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    if (baud_end) begin
                        cnt <= '0;
                        if (stop_cnt == SC_MAX) begin
                            stop_cnt <= 1'b0;
                            state    <= hold_v ? S_START : S_IDLE;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
            endcase
        end
    end

    // Line driver: low for start, LSB of shifter during data, high otherwise.
    always_comb begin
        TxD = 1'b1;
        case (state)
            S_START: TxD = 1'b0;
            S_DATA:  TxD = shift[0];
            default: TxD = 1'b1;
        endcase
    end

endmodule
